// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx_if
// Brief    : Data-memory bus snoop and status read-back bundle for mmio_uart_tx.
// Revision : 1.0
// ============================================================================
interface mmio_uart_tx_if #(
    parameter int N = 32
);
    logic         memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [N-1:0] rdata;
    logic         sel;

    modport master (
        output memwrite, dataadr, writedata,
        input  rdata, sel
    );

    modport slave (
        input  memwrite, dataadr, writedata,
        output rdata, sel
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with byte FIFO and status reg.
// Revision : 1.0
// ============================================================================
module mmio_uart_tx #(
    parameter int           N            = 32,
    parameter int           CLKS_PER_BIT = 16,
    parameter int           FIFO_DEPTH   = 8,
    parameter logic [N-1:0] ADDR_DATA    = 32'hFFFF_FF00,
    parameter logic [N-1:0] ADDR_STATUS  = 32'hFFFF_FF04
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mmio_uart_tx_if.slave      bus,
    output logic               tx,
    output logic               busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                w_push, w_push_ok, w_drop, w_pop, w_clr;
    logic                w_empty, w_full;
    logic [N-1:0]        w_status;
    logic                w_unused;

    assign w_unused  = ^bus.writedata[N-1:8];

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CNT_FULL);
    assign w_push    = bus.memwrite && (bus.dataadr == ADDR_DATA);
    assign w_clr     = bus.memwrite && (bus.dataadr == ADDR_STATUS) && bus.writedata[0];
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_push_ok;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
        endcase

        // Line level follows the state being entered so tx comes straight from a flop.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (w_clr)  ovf_d = 1'b0;
        if (w_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            mem_q[wr_ptr_q] <= bus.writedata[7:0];
        end
    end

    always_comb begin
        w_status             = '0;
        w_status[0]          = w_empty;
        w_status[1]          = w_full;
        w_status[2]          = (state_q != S_IDLE);
        w_status[3]          = ovf_q;
        w_status[8 +: CNT_W] = count_q;
    end

    assign bus.rdata = (bus.dataadr == ADDR_STATUS) ? w_status : '0;
    assign bus.sel   = (bus.dataadr == ADDR_DATA) || (bus.dataadr == ADDR_STATUS);
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, depth 8).
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] ADDR_DATA   = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF04;

    logic clk;
    logic reset;
    logic tx;
    logic busy;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx_if #(.N(32)) bus ();

    mmio_uart_tx #(
        .N            (32),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8),
        .ADDR_DATA    (ADDR_DATA),
        .ADDR_STATUS  (ADDR_STATUS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Background line receiver: samples each bit in its second cycle.
    logic [7:0] rx_bytes [$];
    int         rx_gaps  [$];
    int         frame_errs = 0;
    logic [7:0] rx_b;
    int         rx_idle = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                for (int k = 1; k < 4; k++) begin
                    @(negedge clk);
                    if (tx !== 1'b0) frame_errs++;
                end
                for (int j = 0; j < 8; j++) begin
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        if (k == 1) rx_b[j] = tx;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (tx !== 1'b1) frame_errs++;
                end
                rx_bytes.push_back(rx_b);
                rx_gaps.push_back(rx_idle);
                rx_idle = 0;
            end else begin
                rx_idle++;
            end
        end
    end

    // Inputs set here are sampled by the next rising edge.
    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        bus.memwrite  = we;
        bus.dataadr   = adr;
        bus.writedata = wd;
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] v;
        for (int c = 1; c <= 40; c++) begin
            if (c <= 4)       v[c-1] = 1'b0;
            else if (c <= 36) v[c-1] = b[(c-5)/4];
            else              v[c-1] = 1'b1;
        end
        return v;
    endfunction

    task automatic wait_frames(input int n_frames, input string name);
        int t;
        for (t = 0; t < 1000; t++) begin
            if (rx_bytes.size() >= n_frames && busy === 1'b0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (t >= 1000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d frames busy=%b, required %0d frames then idle",
                     name, rx_bytes.size(), busy, n_frames);
        end
    endtask

    task automatic test_reset();
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'h0;
        bus.writedata = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL reset_sel_other: got %b, required 0", bus.sel); end
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h, required 00000001", bus.rdata); end
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL reset_sel_status: got %b, required 1", bus.sel); end
    endtask

    task automatic test_single_frame();
        logic [39:0] obs;
        rx_bytes.delete(); rx_gaps.delete();
        drive(1'b1, ADDR_DATA, 32'hABCD_0055);
        @(negedge clk);
        bus.memwrite = 1'b0;
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL frame_edge0: got tx=%b busy=%b, required tx=1 busy=1", tx, busy); end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            obs[c-1] = tx;
        end
        checks++; if (obs !== frame_bits(8'h55)) begin errors++; $display("FAIL frame_0x55: got %b, required %b", obs, frame_bits(8'h55)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_edge40: got %b, required 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL frame_end_edge41: got busy=%b tx=%b, required busy=0 tx=1", busy, tx); end
    endtask

    task automatic test_overflow();
        logic ok;
        repeat (5) @(negedge clk);
        rx_bytes.delete(); rx_gaps.delete(); frame_errs = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ADDR_DATA, 32'h0000_0000 + i);
            if (i == 9) begin
                #1;
                checks++; if (bus.rdata !== 32'h0 || bus.sel !== 1'b1) begin errors++; $display("FAIL data_reg_read: got rdata=%h sel=%b, required 00000000 sel=1", bus.rdata, bus.sel); end
            end
        end
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_080E) begin errors++; $display("FAIL overflow_status: got %h, required 0000080e", bus.rdata); end
        wait_frames(9, "overflow");
        checks++; if (rx_bytes.size() !== 9) begin errors++; $display("FAIL overflow_frame_count: got %0d, required 9", rx_bytes.size()); end
        ok = 1'b1;
        for (int i = 0; i < rx_bytes.size(); i++) if (rx_bytes[i] !== 8'(i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL overflow_bytes: got %p, required 0..8 in order", rx_bytes); end
        ok = 1'b1;
        for (int i = 1; i < rx_gaps.size(); i++) if (rx_gaps[i] != 1) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL overflow_gaps: got %p, required 1 idle cycle between frames", rx_gaps); end
        checks++; if (frame_errs != 0) begin errors++; $display("FAIL overflow_framing: got %0d bad start/stop cycles, required 0", frame_errs); end
        #1;
        checks++; if (bus.rdata !== 32'h0000_0009) begin errors++; $display("FAIL overflow_drained_status: got %h, required 00000009", bus.rdata); end
    endtask

    task automatic test_clear_overflow();
        drive(1'b1, ADDR_STATUS, 32'h2);
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0009) begin errors++; $display("FAIL clear_bit1_only: got %h, required 00000009", bus.rdata); end
        drive(1'b1, ADDR_STATUS, 32'h1);
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0001) begin errors++; $display("FAIL clear_overflow: got %h, required 00000001", bus.rdata); end
        drive(1'b1, 32'h0000_0040, 32'h0000_00FF);
        #1;
        checks++; if (bus.sel !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL other_addr_sel: got sel=%b rdata=%h, required sel=0 rdata=0", bus.sel, bus.rdata); end
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0001 || busy !== 1'b0) begin errors++; $display("FAIL other_addr_write: got status=%h busy=%b, required 00000001 busy=0", bus.rdata, busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic idle_ok;
        drive(1'b1, ADDR_DATA, 32'h11);
        drive(1'b1, ADDR_DATA, 32'h22);
        drive(1'b1, ADDR_DATA, 32'h33);
        for (int e = 3; e <= 18; e++) drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0204 || tx !== 1'b0) begin errors++; $display("FAIL pre_reset_state: got status=%h tx=%b, required 00000204 tx=0", bus.rdata, tx); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b, required 1", tx); end
        checks++; if (bus.rdata !== 32'h0000_0001 || busy !== 1'b0) begin errors++; $display("FAIL midframe_reset_status: got %h busy=%b, required 00000001 busy=0", bus.rdata, busy); end
        idle_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        checks++; if (!idle_ok) begin errors++; $display("FAIL midframe_reset_no_frames: got activity on tx, required idle line"); end
    endtask

    task automatic test_push_on_pop();
        logic ok;
        rx_bytes.delete(); rx_gaps.delete(); frame_errs = 0;
        for (int i = 0; i <= 8; i++) drive(1'b1, ADDR_DATA, 32'h0000_00A0 + i);
        for (int e = 9; e <= 41; e++) drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0806) begin errors++; $display("FAIL full_in_stop_status: got %h, required 00000806", bus.rdata); end
        drive(1'b1, ADDR_DATA, 32'h0000_00A9);
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_0806) begin errors++; $display("FAIL push_on_pop_status: got %h, required 00000806", bus.rdata); end
        drive(1'b1, ADDR_DATA, 32'h0000_00AA);
        drive(1'b0, ADDR_STATUS, 32'h0);
        #1;
        checks++; if (bus.rdata !== 32'h0000_080E) begin errors++; $display("FAIL full_drop_status: got %h, required 0000080e", bus.rdata); end
        wait_frames(10, "push_on_pop");
        ok = (rx_bytes.size() == 10);
        for (int i = 0; i < rx_bytes.size(); i++) if (rx_bytes[i] !== 8'(8'hA0 + i)) ok = 1'b0;
        checks++; if (!ok || frame_errs != 0) begin errors++; $display("FAIL push_on_pop_bytes: got %p (framing errs %0d), required a0..a9", rx_bytes, frame_errs); end
    endtask

    initial begin
        reset = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'h0;
        bus.writedata = 32'h0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_clear_overflow();
        test_reset_mid_frame();
        test_push_on_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
